// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined IEEE-754 compare (EQ / LT / LE) with an invalid-operation flag.
// Latency: request captured into stage 1 at the accept edge; result in stage 2 one edge later.
// Backpressure: valid/ready per stage; in_ready = !s1_vld | s2_adv (no in_valid path), outputs hold while !out_ready.
// Ports: clk, rst (async high); in_valid/in_ready/in_op/in_x1/in_x2/in_tag request side;
//        out_valid/out_ready/out_y/out_nv/out_tag result side, driven straight from stage-2 flops.
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [EXP_W+MAN_W:0]   in_x1,
  input  logic [EXP_W+MAN_W:0]   in_x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_y,
  output logic                   out_nv,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int MAG_W = EXP_W + MAN_W;  // {exp, man} magnitude width

  localparam logic [1:0] OP_EQ = 2'b00;
  localparam logic [1:0] OP_LT = 2'b01;
  localparam logic [1:0] OP_LE = 2'b10;

  // Operand classification (combinational, from the request bus)
  logic nan1, nan2, snan1, snan2, zero1, zero2;
  always_comb begin
    nan1  = (&in_x1[MAG_W-1:MAN_W]) & (|in_x1[MAN_W-1:0]);
    nan2  = (&in_x2[MAG_W-1:MAN_W]) & (|in_x2[MAN_W-1:0]);
    snan1 = nan1 & ~in_x1[MAN_W-1];
    snan2 = nan2 & ~in_x2[MAN_W-1];
    zero1 = ~|in_x1[MAG_W-1:0];
    zero2 = ~|in_x2[MAG_W-1:0];
  end

  // Stage 1 state
  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_any_nan_q, s1_any_nan_d;
  logic             s1_any_snan_q, s1_any_snan_d;
  logic             s1_both_zero_q, s1_both_zero_d;
  logic             s1_sgn1_q, s1_sgn1_d;
  logic             s1_sgn2_q, s1_sgn2_d;
  logic             s1_mag_eq_q, s1_mag_eq_d;
  logic             s1_mag_lt_q, s1_mag_lt_d;

  // Stage 2 state
  logic             s2_vld_q, s2_vld_d;
  logic             s2_y_q, s2_y_d;
  logic             s2_nv_q, s2_nv_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic s2_adv;
  logic load1, load2;
  logic res_y, res_nv;

  assign s2_adv   = ~s2_vld_q | out_ready;
  assign in_ready = ~s1_vld_q | s2_adv;
  assign load1    = in_valid & in_ready;
  assign load2    = s2_adv & s1_vld_q;

  // Final decision from stage-1 classification
  always_comb begin
    res_y  = 1'b0;
    res_nv = 1'b0;
    case (s1_op_q)
      OP_EQ: begin
        // +0 == -0; otherwise equality is bit identity, and NaN never equals anything
        res_y  = ~s1_any_nan_q &
                 (s1_both_zero_q | ((s1_sgn1_q == s1_sgn2_q) & s1_mag_eq_q));
        res_nv = s1_any_snan_q;
      end
      OP_LT, OP_LE: begin
        res_nv = s1_any_nan_q;  // ordered compares signal on any NaN, quiet included
        if (s1_any_nan_q) begin
          res_y = 1'b0;
        end else if (s1_both_zero_q) begin
          res_y = s1_op_q[1];  // LE true, LT false
        end else if (s1_sgn1_q != s1_sgn2_q) begin
          res_y = s1_sgn1_q;  // negative operand is the smaller one
        end else if (!s1_sgn1_q) begin
          res_y = s1_mag_lt_q | (s1_op_q[1] & s1_mag_eq_q);
        end else begin
          // both negative: larger magnitude is the smaller value
          res_y = (~s1_mag_lt_q & ~s1_mag_eq_q) | (s1_op_q[1] & s1_mag_eq_q);
        end
      end
      default: begin
        res_y  = 1'b0;
        res_nv = 1'b0;
      end
    endcase
  end

  // Next-state for both stages; data fields only change on a real load
  always_comb begin
    s1_vld_d       = in_ready ? in_valid : s1_vld_q;
    s1_op_d        = s1_op_q;
    s1_tag_d       = s1_tag_q;
    s1_any_nan_d   = s1_any_nan_q;
    s1_any_snan_d  = s1_any_snan_q;
    s1_both_zero_d = s1_both_zero_q;
    s1_sgn1_d      = s1_sgn1_q;
    s1_sgn2_d      = s1_sgn2_q;
    s1_mag_eq_d    = s1_mag_eq_q;
    s1_mag_lt_d    = s1_mag_lt_q;
    if (load1) begin
      s1_op_d        = in_op;
      s1_tag_d       = in_tag;
      s1_any_nan_d   = nan1 | nan2;
      s1_any_snan_d  = snan1 | snan2;
      s1_both_zero_d = zero1 & zero2;
      s1_sgn1_d      = in_x1[MAG_W];
      s1_sgn2_d      = in_x2[MAG_W];
      s1_mag_eq_d    = (in_x1[MAG_W-1:0] == in_x2[MAG_W-1:0]);
      s1_mag_lt_d    = (in_x1[MAG_W-1:0] <  in_x2[MAG_W-1:0]);
    end

    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    s2_y_d   = s2_y_q;
    s2_nv_d  = s2_nv_q;
    s2_tag_d = s2_tag_q;
    if (load2) begin
      s2_y_d   = res_y;
      s2_nv_d  = res_nv;
      s2_tag_d = s1_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q       <= 1'b0;
      s1_op_q        <= 2'b00;
      s1_tag_q       <= '0;
      s1_any_nan_q   <= 1'b0;
      s1_any_snan_q  <= 1'b0;
      s1_both_zero_q <= 1'b0;
      s1_sgn1_q      <= 1'b0;
      s1_sgn2_q      <= 1'b0;
      s1_mag_eq_q    <= 1'b0;
      s1_mag_lt_q    <= 1'b0;
      s2_vld_q       <= 1'b0;
      s2_y_q         <= 1'b0;
      s2_nv_q        <= 1'b0;
      s2_tag_q       <= '0;
    end else begin
      s1_vld_q       <= s1_vld_d;
      s1_op_q        <= s1_op_d;
      s1_tag_q       <= s1_tag_d;
      s1_any_nan_q   <= s1_any_nan_d;
      s1_any_snan_q  <= s1_any_snan_d;
      s1_both_zero_q <= s1_both_zero_d;
      s1_sgn1_q      <= s1_sgn1_d;
      s1_sgn2_q      <= s1_sgn2_d;
      s1_mag_eq_q    <= s1_mag_eq_d;
      s1_mag_lt_q    <= s1_mag_lt_d;
      s2_vld_q       <= s2_vld_d;
      s2_y_q         <= s2_y_d;
      s2_nv_q        <= s2_nv_d;
      s2_tag_q       <= s2_tag_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_y     = s2_y_q;
  assign out_nv    = s2_nv_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: single and half precision instances,
// table of compare vectors plus stream, backpressure and mid-flight reset sequences.
module tb_fcmp_pipe;

  logic        clk;
  logic        rst;

  // single precision instance
  logic        in_valid, in_ready, out_valid, out_ready, out_y, out_nv;
  logic [1:0]  in_op;
  logic [31:0] in_x1, in_x2;
  logic [3:0]  in_tag, out_tag;

  // half precision instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_out_y, h_out_nv;
  logic [1:0]  h_in_op;
  logic [15:0] h_in_x1, h_in_x2;
  logic [3:0]  h_in_tag, h_out_tag;

  int checks = 0;
  int errors = 0;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_nv(out_nv), .out_tag(out_tag)
  );

  fcmp_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
    .in_x1(h_in_x1), .in_x2(h_in_x2), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_y(h_out_y), .out_nv(h_out_nv), .out_tag(h_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        y;
    logic        nv;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one request, then check empty output after the accept edge
  // and the result after the following edge.
  task automatic run_vec(input int idx);
    in_valid  = 1'b1;
    in_op     = vecs[idx].op;
    in_x1     = vecs[idx].x1;
    in_x2     = vecs[idx].x2;
    in_tag    = 4'(idx);
    out_ready = 1'b1;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x1    = 32'hDEADBEEF;
    in_x2    = 32'h12345678;
    chk($sformatf("v%0d_lat1_valid", idx), 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_y", idx), 32'(out_y), 32'(vecs[idx].y));
    chk($sformatf("v%0d_nv", idx), 32'(out_nv), 32'(vecs[idx].nv));
    chk($sformatf("v%0d_tag", idx), 32'(out_tag), 32'(idx[3:0]));
  endtask

  task automatic run_h(input logic [1:0] op, input logic [15:0] x1, input logic [15:0] x2,
                       input logic [3:0] tag, input logic ey, input logic env, input string name);
    h_in_valid  = 1'b1;
    h_in_op     = op;
    h_in_x1     = x1;
    h_in_x2     = x2;
    h_in_tag    = tag;
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    chk({name, "_lat1_valid"}, 32'(h_out_valid), 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 32'(h_out_valid), 32'd1);
    chk({name, "_y"}, 32'(h_out_y), 32'(ey));
    chk({name, "_nv"}, 32'(h_out_nv), 32'(env));
    chk({name, "_tag"}, 32'(h_out_tag), 32'(tag));
  endtask

  initial begin
    int accepts;
    logic [3:0] next_tag;

    vecs[0]  = '{2'd0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0}; // EQ 1.0,1.0
    vecs[1]  = '{2'd0, 32'h00000000, 32'h80000000, 1'b1, 1'b0}; // EQ +0,-0
    vecs[2]  = '{2'd0, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0}; // EQ qNaN
    vecs[3]  = '{2'd0, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1}; // EQ sNaN
    vecs[4]  = '{2'd1, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0}; // LT -2,-1
    vecs[5]  = '{2'd2, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0}; // LE 1,1
    vecs[6]  = '{2'd1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0}; // LT 1,1
    vecs[7]  = '{2'd1, 32'h80000000, 32'h00000000, 1'b0, 1'b0}; // LT -0,+0
    vecs[8]  = '{2'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1}; // LT qNaN
    vecs[9]  = '{2'd2, 32'h00000000, 32'h80000000, 1'b1, 1'b0}; // LE +0,-0
    vecs[10] = '{2'd0, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0}; // EQ +inf
    vecs[11] = '{2'd2, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0}; // LE -1,-2
    vecs[12] = '{2'd1, 32'h00000001, 32'h3F800000, 1'b1, 1'b0}; // LT subnormal,1
    vecs[13] = '{2'd1, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0}; // LT 1,-1
    vecs[14] = '{2'd3, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0}; // reserved op
    vecs[15] = '{2'd2, 32'h7F800001, 32'h7F800001, 1'b0, 1'b1}; // LE sNaN
    vecs[16] = '{2'd0, 32'h00000001, 32'h80000001, 1'b0, 1'b0}; // EQ +/-subnormal
    vecs[17] = '{2'd2, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0}; // LE -2,-1

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'd0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_op = 2'd0; h_in_x1 = '0; h_in_x2 = '0; h_in_tag = '0; h_out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_nv", 32'(out_nv), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven compares
    for (int i = 0; i < NVEC; i++) run_vec(i);
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // back-to-back stream: 8 requests, tags 0..7
    in_valid = 1'b1; in_op = 2'd0; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000;
    in_tag = 4'd0; out_ready = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      chk($sformatf("stream_e%0d_valid", e), 32'(out_valid), 32'((e >= 2) && (e <= 9)));
      if (e >= 2 && e <= 9) begin
        chk($sformatf("stream_e%0d_tag", e), 32'(out_tag), 32'(e - 2));
        chk($sformatf("stream_e%0d_y", e), 32'(out_y), 32'd1);
      end
      chk($sformatf("stream_e%0d_in_ready", e), 32'(in_ready), 32'd1);
      if (e < 8) in_tag = 4'(e);
      else       in_valid = 1'b0;
    end

    // backpressure: A=LT 1<2 (y1,tag8), B=LT 2<1 (y0,tag9), C=EQ 1==1 (y1,tag10)
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd1; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 4'd8;
    accepts = 0;
    next_tag = 4'd8;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_c%0d_in_ready", c), 32'(in_ready), 32'(c < 2));
      if (in_ready) begin
        accepts++;
        next_tag = next_tag + 4'd1;
      end
      @(posedge clk); #1;
      if (next_tag == 4'd9) begin
        in_op = 2'd1; in_x1 = 32'h40000000; in_x2 = 32'h3F800000; in_tag = 4'd9;
      end else begin
        in_op = 2'd0; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 4'd10;
      end
      if (c >= 1) begin
        chk($sformatf("bp_c%0d_out_valid", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp_c%0d_out_y", c), 32'(out_y), 32'd1);
        chk($sformatf("bp_c%0d_out_tag", c), 32'(out_tag), 32'd8);
      end
    end
    chk("bp_accepts", 32'(accepts), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_drain1_valid", 32'(out_valid), 32'd1);
    chk("bp_drain1_tag", 32'(out_tag), 32'd9);
    chk("bp_drain1_y", 32'(out_y), 32'd0);
    @(posedge clk); #1;
    chk("bp_drain2_valid", 32'(out_valid), 32'd1);
    chk("bp_drain2_tag", 32'(out_tag), 32'd10);
    chk("bp_drain2_y", 32'(out_y), 32'd1);
    @(posedge clk); #1;
    chk("bp_drain3_valid", 32'(out_valid), 32'd0);

    // reset with two requests in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 4'd3;
    @(posedge clk); #1;
    in_tag = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstmid_pre_valid", 32'(out_valid), 32'd1);
    chk("rstmid_pre_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_out_tag", 32'(out_tag), 32'd0);
    chk("rstmid_out_y", 32'(out_y), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid_after%0d_valid", k), 32'(out_valid), 32'd0);
    end

    // half precision
    run_h(2'd1, 16'hBC00, 16'h3C00, 4'd1, 1'b1, 1'b0, "h_lt_m1_p1");
    run_h(2'd0, 16'h3C00, 16'h3C00, 4'd2, 1'b1, 1'b0, "h_eq_1_1");
    run_h(2'd1, 16'h7E00, 16'h3C00, 4'd3, 1'b0, 1'b1, "h_lt_qnan");
    run_h(2'd0, 16'h7C01, 16'h3C00, 4'd4, 1'b0, 1'b1, "h_eq_snan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
